// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART frame receiver with a valid/ready output holding register.
// The line is sampled at mid-bit through a 2-flop synchronizer. The framing,
// parity and overrun outcomes are reported as one-cycle pulses.
// Optional feature: define UART_RX_FRAME_PARITY_EN to receive and check a parity
// bit after the data bits. Without it, o_parity_err is tied to 0.
module uart_rx_frame #(
  parameter int G_CLOCK_FREQ      = 20000000,
  parameter int G_BAUDRATE        = 115200,
  parameter int G_DATA_WIDTH      = 8,
  parameter int G_STOP_BIT_NUMBER = 1,
  parameter int G_FIRST_BIT       = 0,
  parameter int G_PARITY          = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_rx,
  output logic [G_DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_parity_err,
  output logic                    o_frame_err,
  output logic                    o_overrun,
  output logic                    o_busy
);

  localparam int C_DIV   = G_CLOCK_FREQ / G_BAUDRATE;
  localparam int C_HALF  = C_DIV / 2;
  localparam int C_CNT_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_BIT_END = C_CNT_W'(C_DIV - 1);
  localparam logic [C_CNT_W-1:0] C_MID_END = C_CNT_W'(C_HALF - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta, rx_s, rx_prev;
  logic [C_CNT_W-1:0]      cnt_q;
  logic [3:0]              bit_cnt_q;
  logic                    stop_cnt_q;
  logic                    stop_err_q;
  logic [G_DATA_WIDTH-1:0] shreg_q;
  logic                    bit_tick, last_data, last_stop;
  logic                    frame_done, frame_bad, parity_bad;

  // Synchronize the asynchronous line and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the pre-edge value of the one before it.
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign bit_tick   = (cnt_q == C_BIT_END);
  assign last_data  = (bit_cnt_q == 4'(G_DATA_WIDTH - 1));
  assign last_stop  = (stop_cnt_q == 1'(G_STOP_BIT_NUMBER - 1));
  assign frame_done = (state_q == S_STOP) && bit_tick && last_stop;
  assign frame_bad  = stop_err_q | ~rx_s;
  assign o_busy     = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start-bit qualification, bit counting, return to idle.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rx_s && rx_prev) state_d = S_START;
      S_START:  if (cnt_q == C_MID_END) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_tick && last_data) begin
`ifdef UART_RX_FRAME_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (bit_tick) state_d = S_STOP;
      S_STOP:   if (bit_tick && last_stop) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Baud/bit counters and the data shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      stop_err_q <= 1'b0;
      // NOTE: the shifter is reset too; it feeds o_data and is cheap to clear.
      shreg_q    <= '0;
    end else begin
      if (state_q == S_IDLE || state_d != state_q || bit_tick) cnt_q <= '0;
      else                                                     cnt_q <= cnt_q + 1'b1;

      if (state_q != S_DATA) bit_cnt_q <= '0;
      else if (bit_tick)     bit_cnt_q <= bit_cnt_q + 1'b1;

      if (state_q != S_STOP) stop_cnt_q <= 1'b0;
      else if (bit_tick)     stop_cnt_q <= stop_cnt_q + 1'b1;

      if (state_q == S_IDLE)                     stop_err_q <= 1'b0;
      else if (state_q == S_STOP && bit_tick && !rx_s) stop_err_q <= 1'b1;

      if (state_q == S_DATA && bit_tick) begin
        if (G_FIRST_BIT == 0) shreg_q <= {rx_s, shreg_q[G_DATA_WIDTH-1:1]};
        else                  shreg_q <= {shreg_q[G_DATA_WIDTH-2:0], rx_s};
      end
    end
  end

`ifdef UART_RX_FRAME_PARITY_EN
  logic par_bit_q;

  assign parity_bad = (((^shreg_q) ^ par_bit_q) != 1'(G_PARITY));

  // Capture the parity bit and flag a bad parity on an otherwise well-framed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit_q    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (state_q == S_PARITY && bit_tick) par_bit_q <= rx_s;
      o_parity_err <= frame_done & ~frame_bad & parity_bad;
    end
  end
`else
  assign parity_bad   = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  // Frame outcome and output holding register with valid/ready handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_done & frame_bad;
      o_overrun   <= 1'b0;
      if (frame_done && !frame_bad && !parity_bad) begin
        if (!o_valid || i_ready) begin
          o_data  <= shreg_q;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench for uart_rx_frame at C_DIV = 10 (8N1, or 8E1
// when UART_RX_FRAME_PARITY_EN is defined). A second instance with MSB-first
// ordering shares the line.
module tb_uart_rx_frame;

  localparam int C_DIV = 10;
`ifdef UART_RX_FRAME_PARITY_EN
  localparam int C_NBITS = 11;  // start + 8 data + parity + stop
`else
  localparam int C_NBITS = 10;  // start + 8 data + stop
`endif
  // Start bit seen on rx_s 2 edges after the drive, START entered on edge 3,
  // DATA on edge 3 + C_HALF = 8, last stop sample on edge 8 + C_DIV*(C_NBITS-1);
  // o_valid is visible in the cycle right after that edge.
  localparam int C_LAT = 8 + C_DIV * (C_NBITS - 1);

  logic       clk, rst_n, i_rx, i_ready;
  logic [7:0] o_data, m_data;
  logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;
  logic       m_valid, m_parity_err, m_frame_err, m_overrun, m_busy;
  logic       m_ready;

  int checks = 0, failures = 0;
  int cyc = 0, frame_start_cyc = 0;
  int rise_cnt, rise_cyc, valid_cycles, perr_cnt, ferr_cnt, ovr_cnt;
  logic valid_prev = 1'b0;

  uart_rx_frame #(
    .G_CLOCK_FREQ(20000000), .G_BAUDRATE(2000000), .G_DATA_WIDTH(8),
    .G_STOP_BIT_NUMBER(1), .G_FIRST_BIT(0), .G_PARITY(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_parity_err(o_parity_err), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  uart_rx_frame #(
    .G_CLOCK_FREQ(20000000), .G_BAUDRATE(2000000), .G_DATA_WIDTH(8),
    .G_STOP_BIT_NUMBER(1), .G_FIRST_BIT(1), .G_PARITY(0)
  ) dut_msb (
    .clk(clk), .rst_n(rst_n), .i_rx(i_rx), .o_data(m_data), .o_valid(m_valid),
    .i_ready(m_ready), .o_parity_err(m_parity_err), .o_frame_err(m_frame_err),
    .o_overrun(m_overrun), .o_busy(m_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and handshake monitor for the LSB-first instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_valid && !valid_prev) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (o_valid)      valid_cycles++;
    if (o_parity_err) perr_cnt++;
    if (o_frame_err)  ferr_cnt++;
    if (o_overrun)    ovr_cnt++;
    valid_prev = o_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    rise_cnt = 0; rise_cyc = 0; valid_cycles = 0;
    perr_cnt = 0; ferr_cnt = 0; ovr_cnt = 0;
  endtask

  // Drive one frame LSB first. bad_par inverts the parity bit (parity builds only),
  // rdy_at > 0 pulses i_ready for exactly one cycle at that offset from the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input logic bad_par, input int rdy_at);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
`ifdef UART_RX_FRAME_PARITY_EN
    bits[n] = (^d) ^ bad_par;
    n++;
`else
    if (bad_par) bits[n] = 1'b1;  // no parity bit on the line in this build
`endif
    bits[n] = stop_v;
    n++;
    @(negedge clk);
    frame_start_cyc = cyc;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < C_DIV; k++) begin
        if (b > 0 || k > 0) @(negedge clk);
        i_rx = bits[b];
        if (rdy_at > 0) i_ready = ((cyc - frame_start_cyc) == rdy_at);
      end
    end
    @(negedge clk);
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; i_rx = 1'b1; i_ready = 1'b1; m_ready = 1'b1;
    rise_cnt = 0; rise_cyc = 0; valid_cycles = 0;
    perr_cnt = 0; ferr_cnt = 0; ovr_cnt = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data",  32'(o_data), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_busy",  32'(o_busy), 32'h0);
    check("rst_pulses", 32'({o_parity_err, o_frame_err, o_overrun}), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(o_busy), 32'h0);

    // Good frame 0xA5, consumer ready: one-cycle valid at the expected latency
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    check("a5_rises",   32'(rise_cnt), 32'd1);
    check("a5_vcycles", 32'(valid_cycles), 32'd1);
    check("a5_data",    32'(o_data), 32'hA5);
    check("a5_latency", 32'(rise_cyc - frame_start_cyc), 32'(C_LAT));
    check("a5_errs",    32'(perr_cnt + ferr_cnt + ovr_cnt), 32'd0);
    check("a5_busy",    32'(o_busy), 32'h0);

    // Overrun: second word dropped while the first is still held
    i_ready = 1'b0;
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    check("ovr_first_valid", 32'(o_valid), 32'h1);
    check("ovr_first_data",  32'(o_data), 32'h3C);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    check("ovr_kept_data", 32'(o_data), 32'h3C);
    check("ovr_pulses",    32'(ovr_cnt), 32'd1);
    check("ovr_rises",     32'(rise_cnt), 32'd1);
    i_ready = 1'b1;
    check("ovr_hold_valid", 32'(o_valid), 32'h1);
    @(negedge clk);
    check("ovr_drop_valid", 32'(o_valid), 32'h0);

    // Accept in the completion cycle: new word loads, valid stays, no overrun
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 0);
    clear_mon();
    send_frame(8'h22, 1'b1, 1'b0, C_LAT - 1);
    check("simul_data",  32'(o_data), 32'h22);
    check("simul_valid", 32'(o_valid), 32'h1);
    check("simul_ovr",   32'(ovr_cnt), 32'd0);
    i_ready = 1'b1;
    @(negedge clk);
    check("simul_drop", 32'(o_valid), 32'h0);

`ifdef UART_RX_FRAME_PARITY_EN
    // Even parity: 0x07 with parity bit 0 is bad, with parity bit 1 is good
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, 0);
    check("par_bad_pulse", 32'(perr_cnt), 32'd1);
    check("par_bad_rises", 32'(rise_cnt), 32'd0);
    check("par_bad_ferr",  32'(ferr_cnt), 32'd0);
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("par_good_data",  32'(o_data), 32'h07);
    check("par_good_rises", 32'(rise_cnt), 32'd1);
    check("par_good_perr",  32'(perr_cnt), 32'd0);
`endif

    // Framing error: stop bit low
    clear_mon();
    send_frame(8'h55, 1'b0, 1'b0, 0);
    check("ferr_pulse", 32'(ferr_cnt), 32'd1);
    check("ferr_rises", 32'(rise_cnt), 32'd0);
    check("ferr_perr",  32'(perr_cnt), 32'd0);

    // 3-cycle glitch: START entered then rejected silently
    clear_mon();
    @(negedge clk);
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_on", 32'(o_busy), 32'h1);
    i_rx = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch_busy_off", 32'(o_busy), 32'h0);
    check("glitch_pulses",   32'(ferr_cnt + perr_cnt + rise_cnt), 32'd0);

    // Break: one framing error, then parked in IDLE until the line returns high
    clear_mon();
    i_rx = 1'b0;
    repeat (250) @(negedge clk);
    check("break_ferr",  32'(ferr_cnt), 32'd1);
    check("break_busy",  32'(o_busy), 32'h0);
    check("break_rises", 32'(rise_cnt), 32'd0);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    check("break_after_data", 32'(o_data), 32'h5A);
    check("break_after_ferr", 32'(ferr_cnt), 32'd1);

    // Reset during bit 4 of 0xF0 (a '1' bit), then a clean 0x12
    clear_mon();
    @(negedge clk);
    i_rx = 1'b0;
    repeat (5 * C_DIV) @(negedge clk);
    i_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy",  32'(o_busy), 32'h0);
    check("midrst_valid", 32'(o_valid), 32'h0);
    check("midrst_data",  32'(o_data), 32'h0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("midrst_idle", 32'(o_busy), 32'h0);
    send_frame(8'h12, 1'b1, 1'b0, 0);
    check("midrst_rises",  32'(rise_cnt), 32'd1);
    check("midrst_data12", 32'(o_data), 32'h12);
    check("midrst_errs",   32'(perr_cnt + ferr_cnt + ovr_cnt), 32'd0);

    // Line bits 1,0,0,0,0,0,0,0: LSB-first gives 0x01, MSB-first gives 0x80
    send_frame(8'h01, 1'b1, 1'b0, 0);
    check("lsb_first_data", 32'(o_data), 32'h01);
    check("msb_first_data", 32'(m_data), 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- G_CLOCK_FREQ, 20000000, clk frequency in Hz.
- G_BAUDRATE, 115200, line rate in bit/s.
- G_DATA_WIDTH, 8, data bits per frame, range 5..9.
- G_STOP_BIT_NUMBER, 1, stop bits, range 1..2.
- G_FIRST_BIT, 0, bit order: 0 = LSB first, 1 = MSB first.
- G_PARITY, 0, parity type: 0 = even, 1 = odd.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- i_rx, in, 1, asynchronous serial line, idle high.
- o_data, out, G_DATA_WIDTH, received word.
- o_valid, out, 1, o_data holds a frame.
- i_ready, in, 1, consumer accepts o_data.
- o_parity_err, out, 1, one-cycle pulse.
- o_frame_err, out, 1, one-cycle pulse.
- o_overrun, out, 1, one-cycle pulse.
- o_busy, out, 1, frame reception in progress.

Function
REQ-003 The block SHALL pass i_rx through a 2-flop synchronizer; all logic SHALL use the synchronized value rx_s.
REQ-004 Bit period SHALL be C_DIV = G_CLOCK_FREQ / G_BAUDRATE, truncated; half period SHALL be C_HALF = C_DIV / 2, truncated.
REQ-005 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-006 IDLE -> START SHALL occur on the first cycle rx_s = 0 after rx_s = 1. The baud counter SHALL clear on this transition.
REQ-007 START: at counter = C_HALF - 1, if rx_s = 0 the FSM SHALL go to DATA; otherwise it SHALL return to IDLE (glitch reject). Neither case raises an error.
REQ-008 DATA SHALL sample rx_s every C_DIV cycles, G_DATA_WIDTH times, and place bits per G_FIRST_BIT. The next state SHALL be PARITY if parity is compiled in, else STOP.
REQ-009 PARITY SHALL take one sample C_DIV cycles later. Parity error is defined as: XOR of the data bits and the sampled parity bit != G_PARITY.
REQ-010 STOP SHALL sample G_STOP_BIT_NUMBER bits at C_DIV spacing. Any sample = 0 SHALL be a framing error.
REQ-011 After the last stop-bit sample the FSM SHALL return to IDLE. The next falling edge SHALL be accepted from the following cycle.
REQ-012 Frame outcome on a good frame: o_data SHALL load and o_valid SHALL assert exactly 1 cycle after the last stop-bit sample.
REQ-013 Frame outcome on a framing error: o_frame_err SHALL pulse and no data SHALL load. Framing error takes priority over parity error.
REQ-014 Frame outcome on a parity error: o_parity_err SHALL pulse and no data SHALL load.
REQ-015 Handshake: o_valid and o_data SHALL hold until the cycle in which o_valid = 1 and i_ready = 1; o_valid SHALL drop the following cycle.
REQ-016 Overrun: if a good frame completes while o_valid = 1 and i_ready = 0 in that cycle, the new word SHALL be dropped, o_data SHALL be kept, and o_overrun SHALL pulse.
REQ-017 Simultaneous accept and completion: if i_ready = 1 in the completion cycle, the new word SHALL load and o_valid SHALL stay 1, with no overrun.
REQ-018 o_busy SHALL be 1 in every state except IDLE.
REQ-019 A line held low (break) SHALL produce a framing error, then remain in IDLE until rx_s returns to 1.

Reset
REQ-020 While rst_n = 0, the block SHALL force: FSM = IDLE, counters = 0, synchronizer flops = 1, o_data = 0, and o_valid, o_parity_err, o_frame_err, o_overrun, o_busy = 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no pulse. After release, reception SHALL restart only on a new 1->0 edge.

Configuration
REQ-022 Macro UART_RX_FRAME_PARITY_EN, when defined, SHALL include the PARITY state and o_parity_err logic. When undefined, frames SHALL carry no parity bit and o_parity_err SHALL be tied to 0.

Verification
Bench settings: G_CLOCK_FREQ = 20000000, G_BAUDRATE = 2000000, C_DIV = 10, 8N1 unless stated.
REQ-023 Send 0xA5, LSB first, i_ready = 1 -> o_valid = 1 for 1 cycle, o_data = 0xA5, 1 cycle after the stop sample.
REQ-024 Send 0x3C then 0x81 with i_ready = 0 -> o_data stays 0x3C and o_overrun pulses once. Then raise i_ready -> o_valid drops the next cycle.
REQ-025 With PARITY_EN and G_PARITY = 0, send 0x07 with parity bit 0 -> o_parity_err pulses and o_valid stays 0. Resend with parity bit 1 -> o_data = 0x07.
REQ-026 Send 0x55 with stop bit = 0 -> o_frame_err pulses and o_valid stays 0. A 3-cycle low glitch on i_rx -> no error, o_busy returns to 0.
REQ-027 Assert rst_n = 0 during bit 4 of 0xF0, then release and send 0x12 -> only 0x12 is delivered, with no error pulses.
REQ-028 G_FIRST_BIT = 1, send line bits 1,0,0,0,0,0,0,0 -> o_data = 0x80.
